// File: rtl/tiny_rv_wb_timer_if.sv
// Pipelined Wishbone bundle between the core bus and the machine timer.
// Signal names are seen from the timer (slave) side.
interface tiny_rv_wb_timer_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [29:0] i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic        o_wb_err;
    logic [31:0] o_wb_data;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_ack, o_wb_stall, o_wb_err, o_wb_data
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_ack, o_wb_stall, o_wb_err, o_wb_data
    );
endinterface

// File: rtl/tiny_rv_wb_timer.sv
// RISC-V machine timer (mtime/mtimecmp) with prescaler, as a never-stalling
// pipelined Wishbone responder; one ack or err per accepted transfer.
module tiny_rv_wb_timer #(
    parameter int unsigned PRESCALE_W   = 16,
    parameter bit          RESET_ENABLE = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    tiny_rv_wb_timer_if.slave wb,
    output logic              o_irq
);
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 64;

    typedef enum logic [2:0] {
        OFF_MTIME_LO    = 3'd0,
        OFF_MTIME_HI    = 3'd1,
        OFF_MTIMECMP_LO = 3'd2,
        OFF_MTIMECMP_HI = 3'd3,
        OFF_CTRL        = 3'd4,
        OFF_PRESCALE    = 3'd5,
        OFF_RSV6        = 3'd6,
        OFF_RSV7        = 3'd7
    } reg_off_e;

    logic [TW-1:0]         mtime_q, mtime_d;
    logic [TW-1:0]         mtimecmp_q, mtimecmp_d;
    logic                  enable_q, enable_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  irq_q, irq_d;

    logic     accept;
    logic     mapped;
    logic     wr;
    logic     tick;
    reg_off_e off;
    logic     unused_addr;

    // Byte-lane merge of write data into an existing 32-bit word.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [3:0]    sel);
        logic [DW-1:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    assign unused_addr = ^wb.i_wb_addr[29:3];

    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        enable_d   = enable_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        shadow_d   = shadow_q;
        rdata_d    = rdata_q;

        accept = wb.i_wb_cyc & wb.i_wb_stb;
        off    = reg_off_e'(wb.i_wb_addr[2:0]);
        mapped = (off != OFF_RSV6) && (off != OFF_RSV7);
        wr     = accept & wb.i_wb_we & mapped;
        tick   = enable_q && (pcnt_q == prescale_q);

        if (enable_q) begin
            pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
            if (tick) mtime_d = mtime_q + TW'(1);
        end

        // Writes are merged into the pre-edge value, so a same-cycle tick is dropped.
        if (wr) begin
            case (off)
                OFF_MTIME_LO:    mtime_d = {mtime_q[63:32],
                                            merge_bytes(mtime_q[31:0], wb.i_wb_data, wb.i_wb_sel)};
                OFF_MTIME_HI:    mtime_d = {merge_bytes(mtime_q[63:32], wb.i_wb_data, wb.i_wb_sel),
                                            mtime_q[31:0]};
                OFF_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32],
                                               merge_bytes(mtimecmp_q[31:0], wb.i_wb_data, wb.i_wb_sel)};
                OFF_MTIMECMP_HI: mtimecmp_d = {merge_bytes(mtimecmp_q[63:32], wb.i_wb_data, wb.i_wb_sel),
                                               mtimecmp_q[31:0]};
                OFF_CTRL: begin
                    if (wb.i_wb_sel[0]) enable_d = wb.i_wb_data[0];
                end
                OFF_PRESCALE: begin
                    prescale_d = PRESCALE_W'(merge_bytes(DW'(prescale_q), wb.i_wb_data, wb.i_wb_sel));
                    pcnt_d     = '0;
                end
                default: ;
            endcase
        end

        // LO read snapshots HI so a following HI read pairs with it atomically.
        if (accept && !wb.i_wb_we) begin
            case (off)
                OFF_MTIME_LO: begin
                    rdata_d  = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                OFF_MTIME_HI:    rdata_d = shadow_q;
                OFF_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                OFF_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                OFF_CTRL:        rdata_d = DW'(enable_q);
                OFF_PRESCALE:    rdata_d = DW'(prescale_q);
                default:         rdata_d = '0;
            endcase
        end

        ack_d = accept & mapped;
        err_d = accept & ~mapped;
        irq_d = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            enable_q   <= RESET_ENABLE;
            prescale_q <= '0;
            pcnt_q     <= '0;
            shadow_q   <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            enable_q   <= enable_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            irq_q      <= irq_d;
        end
    end

    // Responses are suppressed when the master has abandoned the cycle.
    assign wb.o_wb_ack   = ack_q & wb.i_wb_cyc;
    assign wb.o_wb_err   = err_q & wb.i_wb_cyc;
    assign wb.o_wb_stall = 1'b0;
    assign wb.o_wb_data  = rdata_q;
    assign o_irq         = irq_q;
endmodule

// File: tb/tb_tiny_rv_wb_timer.sv
// Directed bench for tiny_rv_wb_timer: register table plus multi-cycle
// sequences for prescaler, atomic read, interrupt, abort and reset.
module tb_tiny_rv_wb_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;

    tiny_rv_wb_timer_if wb_if ();

    tiny_rv_wb_timer #(.PRESCALE_W(16), .RESET_ENABLE(1'b1)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .wb      (wb_if.slave),
        .o_irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  a;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic        e_ack;
        logic        e_err;
        logic        cd;
        logic [31:0] e_d;
    } vec_t;

    vec_t vt[17];

    int total = 0;
    int bad   = 0;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_if.i_wb_cyc  = 1'b1;
        wb_if.i_wb_stb  = 1'b1;
        wb_if.i_wb_we   = we;
        wb_if.i_wb_addr = {27'd0, a};
        wb_if.i_wb_data = d;
        wb_if.i_wb_sel  = s;
    endtask

    task automatic sample();
        wb_if.i_wb_stb = 1'b0;
        wb_if.i_wb_we  = 1'b0;
        r_ack  = wb_if.o_wb_ack;
        r_err  = wb_if.o_wb_err;
        r_data = wb_if.o_wb_data;
    endtask

    task automatic xfer(input logic we, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        drive(we, a, d, s);
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic idle(input int n);
        wb_if.i_wb_cyc = 1'b0;
        wb_if.i_wb_stb = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        xfer(1'b1, a, d, 4'hF);
        chk("write ack", 64'(r_ack), 64'd1);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        xfer(1'b0, a, 32'd0, 4'hF);
        chk({name, " ack"}, 64'(r_ack), 64'd1);
        chk(name, 64'(r_data), 64'(exp));
    endtask

    task automatic abort_chk(input string name, input logic we, input logic [2:0] a, input logic [31:0] d);
        drive(we, a, d, 4'hF);
        @(posedge clk);
        #1;
        wb_if.i_wb_cyc = 1'b0;
        wb_if.i_wb_stb = 1'b0;
        #1;
        chk({name, " ack"}, 64'(wb_if.o_wb_ack), 64'd0);
        chk({name, " err"}, 64'(wb_if.o_wb_err), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          we    a     wdata         sel   ack   err   cd    exp
        vt[0]  = '{1'b0, 3'd0, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
        vt[1]  = '{1'b0, 3'd1, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
        vt[2]  = '{1'b0, 3'd2, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vt[3]  = '{1'b0, 3'd3, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vt[4]  = '{1'b0, 3'd4, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_0001};
        vt[5]  = '{1'b0, 3'd5, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
        vt[6]  = '{1'b1, 3'd2, 32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 3'd2, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hFFBB_FFDD};
        vt[8]  = '{1'b1, 3'd6, 32'h12345678, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{1'b0, 3'd7, 32'h0,        4'hF, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[10] = '{1'b0, 3'd2, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hFFBB_FFDD};
        vt[11] = '{1'b1, 3'd3, 32'h0,        4'h0, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[12] = '{1'b0, 3'd3, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vt[13] = '{1'b1, 3'd5, 32'h12345678, 4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[14] = '{1'b0, 3'd5, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_5678};
        vt[15] = '{1'b1, 3'd4, 32'h0,        4'hF, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[16] = '{1'b0, 3'd4, 32'h0,        4'hF, 1'b1, 1'b0, 1'b1, 32'h0000_0000};

        wb_if.i_wb_cyc  = 1'b0;
        wb_if.i_wb_stb  = 1'b0;
        wb_if.i_wb_we   = 1'b0;
        wb_if.i_wb_addr = '0;
        wb_if.i_wb_data = '0;
        wb_if.i_wb_sel  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset ack", 64'(wb_if.o_wb_ack), 64'd0);
        chk("reset err", 64'(wb_if.o_wb_err), 64'd0);
        chk("reset irq", 64'(irq), 64'd0);
        chk("reset data", 64'(wb_if.o_wb_data), 64'd0);

        // Table: first row is accepted on the first edge after reset release.
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].we, vt[i].a, vt[i].wd, vt[i].sel);
            if (i == 0) begin
                #2;
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
            sample();
            chk($sformatf("vec%0d ack", i), 64'(r_ack), 64'(vt[i].e_ack));
            chk($sformatf("vec%0d err", i), 64'(r_err), 64'(vt[i].e_err));
            if (vt[i].cd) chk($sformatf("vec%0d data", i), 64'(r_data), 64'(vt[i].e_d));
            chk($sformatf("vec%0d irq", i), 64'(irq), 64'd0);
            chk($sformatf("vec%0d stall", i), 64'(wb_if.o_wb_stall), 64'd0);
        end

        // Prescaler 3: one tick per 4 enabled cycles, frozen once disabled.
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0);
        wr(3'd5, 32'd3);
        wr(3'd4, 32'd1);
        idle(15);
        wr(3'd4, 32'd0);
        rd_chk("presc mtime", 3'd0, 32'd4);
        idle(20);
        rd_chk("frozen mtime lo", 3'd0, 32'd4);
        rd_chk("frozen mtime hi", 3'd1, 32'd0);

        // Atomic LO/HI pairs across the 32-bit carry.
        wr(3'd1, 32'h0);
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd5, 32'd0);
        wr(3'd4, 32'd1);
        rd_chk("pair0 lo", 3'd0, 32'hFFFF_FFFE);
        rd_chk("pair0 hi", 3'd1, 32'h0);
        rd_chk("pair1 lo", 3'd0, 32'h0000_0000);
        rd_chk("pair1 hi", 3'd1, 32'h1);
        rd_chk("pair2 lo", 3'd0, 32'h0000_0002);
        rd_chk("pair2 hi", 3'd1, 32'h1);
        // A write in a tick cycle wins; counting resumes next cycle.
        wr(3'd0, 32'h100);
        rd_chk("write wins", 3'd0, 32'h100);
        rd_chk("after write", 3'd0, 32'h101);
        wr(3'd4, 32'd0);
        rd_chk("shadow hi", 3'd1, 32'h1);

        // Interrupt at mtime == 0x10, cleared by raising mtimecmp.
        wr(3'd1, 32'h0);
        wr(3'd0, 32'h0);
        wr(3'd3, 32'h0);
        wr(3'd2, 32'h10);
        idle(2);
        chk("irq below cmp", 64'(irq), 64'd0);
        wr(3'd4, 32'd1);
        idle(16);
        chk("irq at mtime 15", 64'(irq), 64'd0);
        idle(1);
        chk("irq at mtime 16", 64'(irq), 64'd1);
        wr(3'd3, 32'h1);
        chk("irq same cycle", 64'(irq), 64'd1);
        idle(1);
        chk("irq dropped", 64'(irq), 64'd0);
        wr(3'd4, 32'd0);

        // Aborted cycles: no response, write side effect still lands.
        abort_chk("abort read", 1'b0, 3'd2, 32'h0);
        abort_chk("abort write", 1'b1, 3'd2, 32'h55);
        abort_chk("abort err", 1'b0, 3'd6, 32'h0);
        rd_chk("aborted write kept", 3'd2, 32'h55);

        // Reset in the middle of a read burst.
        drive(1'b0, 3'd3, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        drive(1'b0, 3'd2, 32'h0, 4'hF);
        chk("burst ack", 64'(wb_if.o_wb_ack), 64'd1);
        chk("burst data", 64'(wb_if.o_wb_data), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst ack", 64'(wb_if.o_wb_ack), 64'd0);
        chk("rst data", 64'(wb_if.o_wb_data), 64'd0);
        chk("rst irq", 64'(irq), 64'd0);
        drive(1'b0, 3'd0, 32'h0, 4'hF);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        sample();
        chk("post-rst ack", 64'(r_ack), 64'd1);
        chk("post-rst mtime lo", 64'(r_data), 64'd0);
        rd_chk("post-rst mtime hi", 3'd1, 32'h0);
        rd_chk("post-rst cmp lo", 3'd2, 32'hFFFF_FFFF);
        rd_chk("post-rst cmp hi", 3'd3, 32'hFFFF_FFFF);
        rd_chk("post-rst ctrl", 3'd4, 32'h1);
        rd_chk("post-rst presc", 3'd5, 32'h0);
        idle(1);
        chk("idle ack", 64'(wb_if.o_wb_ack), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
